// File: rtl/prog_sequencer_if.sv
// ROM fetch and datapath handshake between the program sequencer and its neighbours.
interface prog_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 9
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] dp_din;
  logic              dp_run;
  logic              dp_take;
  logic              dp_done;

  modport master (
    output rom_addr,
    output dp_din,
    output dp_run,
    input  rom_q,
    input  dp_take,
    input  dp_done
  );

  modport slave (
    input  rom_addr,
    input  dp_din,
    input  dp_run,
    output rom_q,
    output dp_take,
    output dp_done
  );
endinterface

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches ROM words, presents them to the datapath and
// issues one run pulse per instruction, advancing on take and retiring on done.
module prog_sequencer #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned LAST_ADDR = 31,
  parameter bit          WRAP      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  prog_sequencer_if.master bus,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [2:0]       state,
  output logic [7:0]       icount
);
  localparam int unsigned LAT_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    EXEC   = 3'd3,
    REFILL = 3'd4,
    HALTED = 3'd5
  } st_t;

  st_t               st;
  logic [ADDR_W-1:0] pc;
  logic [LAT_W-1:0]  lat_cnt;
  logic              din_valid;
  logic              stop_l;
  logic              end_f;
  logic              done_pend;

  logic lat_last;
  logic pc_last;
  logic take_ok;
  logic end_now;
  logic halt_req;

  assign lat_last = (lat_cnt == LAT_W'(ROM_LAT));
  assign pc_last  = (pc == ADDR_W'(LAST_ADDR));
  // A take is only legal while a held word is waiting in EXEC
  assign take_ok  = (st == EXEC) && din_valid && bus.dp_take;
  assign end_now  = end_f || (take_ok && pc_last && !WRAP);
  assign halt_req = stop_l || stop;

  assign bus.rom_addr = pc;
  assign state        = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      pc         <= '0;
      lat_cnt    <= '0;
      din_valid  <= 1'b0;
      stop_l     <= 1'b0;
      end_f      <= 1'b0;
      done_pend  <= 1'b0;
      bus.dp_din <= '0;
      bus.dp_run <= 1'b0;
      err        <= 1'b0;
      icount     <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      bus.dp_run <= 1'b0;

      if (busy && stop) stop_l <= 1'b1;
      if (bus.dp_take && !take_ok) err <= 1'b1;
      if (bus.dp_done && ((st == EXEC) || (st == REFILL)) && (icount != '1))
        icount <= icount + CNT_W'(1);

      case (st)
        IDLE: begin
          if (start) begin
            pc        <= '0;
            stop_l    <= 1'b0;
            end_f     <= 1'b0;
            done_pend <= 1'b0;
            lat_cnt   <= '0;
            din_valid <= 1'b0;
            st        <= FETCH;
            busy      <= 1'b1;
          end
        end

        // Both wait out the ROM latency on a stable address, then capture the word
        FETCH, REFILL: begin
          if (lat_last) begin
            lat_cnt    <= '0;
            bus.dp_din <= DATA_W'(bus.rom_q);
            din_valid  <= 1'b1;
            if ((st == FETCH) || done_pend || bus.dp_done) begin
              done_pend <= 1'b0;
              if ((st == REFILL) && halt_req) begin
                st     <= HALTED;
                busy   <= 1'b0;
                halted <= 1'b1;
              end else begin
                st         <= ISSUE;
                bus.dp_run <= 1'b1;
              end
            end else begin
              st <= EXEC;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
            if ((st == REFILL) && bus.dp_done) done_pend <= 1'b1;
          end
        end

        ISSUE: st <= EXEC;

        EXEC: begin
          if (take_ok) begin
            din_valid <= 1'b0;
            if (!pc_last)  pc    <= pc + ADDR_W'(1);
            else if (WRAP) pc    <= '0;
            else            end_f <= 1'b1;
          end
          if (bus.dp_done) begin
            if (end_now || halt_req) begin
              st     <= HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else if (take_ok) begin
              // Done arrived with the take: refill first, then issue
              st        <= REFILL;
              done_pend <= 1'b1;
            end else if (din_valid) begin
              st         <= ISSUE;
              bus.dp_run <= 1'b1;
            end
          end else if (take_ok && !end_now) begin
            st <= REFILL;
          end
        end

        HALTED: begin
          if (start) begin
            if (end_f && !WRAP) pc <= '0;
            stop_l    <= 1'b0;
            end_f     <= 1'b0;
            done_pend <= 1'b0;
            lat_cnt   <= '0;
            din_valid <= 1'b0;
            st        <= FETCH;
            busy      <= 1'b1;
            halted    <= 1'b0;
          end
        end

        default: begin
          st     <= IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Run pulses are single-cycle, coincide with ISSUE and always carry a held word
  a_run_valid : assert property (@(posedge clk) disable iff (!rst) bus.dp_run |-> din_valid);
  a_run_issue : assert property (@(posedge clk) disable iff (!rst) bus.dp_run == (st == ISSUE));
  a_run_pulse : assert property (@(posedge clk) disable iff (!rst) bus.dp_run |=> !bus.dp_run);

endmodule
